dsp38_mac_accum: RTL and testbench

- Downstream stage of the DSP38 multiply-only instance. Consumes its 38-bit Z product stream and accumulates a frame of N products into a 48-bit result. This turns the combinational multiplier into a multiply-accumulate / dot-product engine.
- Provides a valid/ready handshake on both sides and optional saturation. Reports overflow once per frame.

---
 rtl/dsp38_mac_accum.sv | 107 ++++++++++
 tb/tb_dsp38_mac_accum.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dsp38_mac_accum.sv
// Frame accumulator for the DSP38 product stream: sums frame_len products into
// an ACC_W result, with optional saturation and a per-frame sticky overflow flag.
module dsp38_mac_accum #(
  parameter int PROD_W = 38,
  parameter int ACC_W  = 48,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_signed,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              sat_en,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              overflow,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [ACC_W-1:0] acc, ext, acc_nxt, sat_val;
  logic [ACC_W:0]   sum_full;
  logic [LEN_W-1:0] cnt, cnt_inc, len_q;
  logic             sgn_q, sat_q, ovf_q;
  logic             sgn_eff, beat, last, carry_out, carry_msb, add_ovf, len_one;

  assign beat    = prod_valid & prod_ready;
  assign len_one = (frame_len == LEN_W'(1));

  // The first beat uses the live signedness; later beats use the latched one.
  assign sgn_eff = (state == S_IDLE) ? prod_signed : sgn_q;
  assign ext     = sgn_eff ? {{(ACC_W-PROD_W){prod_in[PROD_W-1]}}, prod_in}
                           : {{(ACC_W-PROD_W){1'b0}}, prod_in};

  assign sum_full  = {1'b0, acc} + {1'b0, ext};
  assign carry_out = sum_full[ACC_W];
  assign carry_msb = acc[ACC_W-1] ^ ext[ACC_W-1] ^ sum_full[ACC_W-1];
  assign add_ovf   = sgn_q ? (carry_msb ^ carry_out) : carry_out;

  // A signed overflow implies both operands share a sign; that is the true sum's sign.
  assign sat_val = sgn_q ? (ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                         : {1'b0, {(ACC_W-1){1'b1}}})
                         : {ACC_W{1'b1}};
  assign acc_nxt = (add_ovf & sat_q) ? sat_val : sum_full[ACC_W-1:0];

  // Length 0 encodes 2^LEN_W: the incremented count wraps to 0 on the last beat.
  assign cnt_inc = cnt + LEN_W'(1);
  assign last    = (cnt_inc == len_q);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (beat) state_nxt = len_one ? S_HOLD : S_ACCUM;
      S_ACCUM: if (beat && last) state_nxt = S_HOLD;
      S_HOLD:  if (acc_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      prod_ready <= 1'b0;
      acc        <= '0;
      acc_out    <= '0;
      cnt        <= '0;
      len_q      <= '0;
      sgn_q      <= 1'b0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      // Registered so it stays low through reset and drops on the edge entering HOLD.
      prod_ready <= (state_nxt != S_HOLD);
      case (state)
        S_IDLE: if (beat) begin
          len_q <= frame_len;
          sgn_q <= prod_signed;
          sat_q <= sat_en;
          acc   <= ext;
          cnt   <= LEN_W'(1);
          ovf_q <= 1'b0;
          if (len_one) acc_out <= ext;
        end
        S_ACCUM: if (beat) begin
          acc   <= acc_nxt;
          cnt   <= cnt_inc;
          ovf_q <= ovf_q | add_ovf;
          if (last) acc_out <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign acc_valid = (state == S_HOLD);
  assign overflow  = acc_valid & ovf_q;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_dsp38_mac_accum.sv
// Directed bench for dsp38_mac_accum. A 40-bit accumulator is used so that
// 256-beat frames of 38-bit products can actually overflow and saturate.
module tb_dsp38_mac_accum;
  localparam int PW = 38;
  localparam int AW = 40;
  localparam int LW = 8;

  logic          clk, rst_n;
  logic [PW-1:0] prod_in;
  logic          prod_signed, prod_valid, prod_ready;
  logic [LW-1:0] frame_len;
  logic          sat_en;
  logic [AW-1:0] acc_out;
  logic          acc_valid, acc_ready, overflow, busy;

  int checks = 0;
  int errors = 0;

  dsp38_mac_accum #(.PROD_W(PW), .ACC_W(AW), .LEN_W(LW)) u_dut (
    .clk(clk), .rst_n(rst_n), .prod_in(prod_in), .prod_signed(prod_signed),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .frame_len(frame_len),
    .sat_en(sat_en), .acc_out(acc_out), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic beat(input logic [PW-1:0] p);
    int n = 0;
    prod_in    = p;
    prod_valid = 1'b1;
    while (!prod_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!prod_ready) chk("beat_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    prod_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input logic [AW-1:0] ea, input logic eo);
    int n = 0;
    while (!acc_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, 64'(acc_valid), 1);
    chk({tag, "_acc"}, 64'(acc_out), 64'(ea));
    chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
    @(negedge clk);
  endtask

  task automatic cfg(input logic [LW-1:0] len, input logic sgn, input logic sat);
    frame_len   = len;
    prod_signed = sgn;
    sat_en      = sat;
  endtask

  initial begin
    rst_n = 1'b0; prod_in = '0; prod_valid = 1'b0; acc_ready = 1'b1;
    cfg(8'd0, 1'b0, 1'b0);
    #3;
    chk("rst_acc_out", 64'(acc_out), 0);
    chk("rst_acc_valid", 64'(acc_valid), 0);
    chk("rst_overflow", 64'(overflow), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_prod_ready", 64'(prod_ready), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_prod_ready", 64'(prod_ready), 1);

    // Signed dot product summing to zero; result visible for exactly one cycle.
    cfg(8'd4, 1'b1, 1'b0);
    beat(PW'(100));
    chk("dot_busy", 64'(busy), 1);
    beat(PW'(-30)); beat(PW'(7)); beat(PW'(-77));
    chk("dot_vld", 64'(acc_valid), 1);
    chk("dot_acc", 64'(acc_out), 0);
    chk("dot_ovf", 64'(overflow), 0);
    @(negedge clk);
    chk("dot_vld_drop", 64'(acc_valid), 0);

    // Unsigned: 2 x 2^37 = 2^38, no overflow.
    cfg(8'd2, 1'b0, 1'b0);
    repeat (2) beat(38'h20_0000_0000);
    wait_res("uns2", 40'h40_0000_0000, 1'b0);

    // Unsigned wrap: 256 x 2^37 = 2^45 = 0 mod 2^40.
    cfg(8'd0, 1'b0, 1'b0);
    repeat (256) beat(38'h20_0000_0000);
    wait_res("uwrap", 40'h0, 1'b1);

    // Signed saturation, positive and negative.
    cfg(8'd0, 1'b1, 1'b1);
    repeat (256) beat(38'h1F_FFFF_FFFF);
    wait_res("ssat_pos", 40'h7F_FFFF_FFFF, 1'b1);
    cfg(8'd0, 1'b1, 1'b1);
    repeat (256) beat(38'h20_0000_0000);
    wait_res("ssat_neg", 40'h80_0000_0000, 1'b1);

    // 4 x (2^37-1) = 2^39-4, +(2^37-1) clamps to 2^39-1, then -5 continues from the clamp.
    cfg(8'd6, 1'b1, 1'b1);
    repeat (5) beat(38'h1F_FFFF_FFFF);
    beat(PW'(-5));
    wait_res("ssat_cont", 40'h7F_FFFF_FFFA, 1'b1);

    // Unsigned saturation: 8 x 2^37 = 2^40 clamps to all ones.
    cfg(8'd8, 1'b0, 1'b1);
    repeat (8) beat(38'h20_0000_0000);
    wait_res("usat", 40'hFF_FFFF_FFFF, 1'b1);

    // Backpressure: result held, no beats accepted while HOLD.
    acc_ready = 1'b0;
    cfg(8'd1, 1'b0, 1'b0);
    beat(PW'(5));
    prod_in = PW'(9); prod_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_ready_%0d", i), 64'(prod_ready), 0);
      chk($sformatf("bp_acc_%0d", i), 64'(acc_out), 5);
      chk($sformatf("bp_vld_%0d", i), 64'(acc_valid), 1);
      @(negedge clk);
    end
    chk("bp_ovf", 64'(overflow), 0);
    acc_ready = 1'b1;
    @(negedge clk);
    chk("bp_vld_drop", 64'(acc_valid), 0);
    chk("bp_ready_back", 64'(prod_ready), 1);
    @(negedge clk);
    prod_valid = 1'b0;
    chk("bp_next_vld", 64'(acc_valid), 1);
    chk("bp_next_acc", 64'(acc_out), 9);
    @(negedge clk);

    // Gapped beats; frame_len change mid-frame is ignored.
    cfg(8'd3, 1'b0, 1'b0);
    beat(PW'(1));
    frame_len = 8'd9;
    repeat (4) @(negedge clk);
    chk("gap_busy", 64'(busy), 1);
    beat(PW'(2));
    repeat (4) @(negedge clk);
    beat(PW'(3));
    wait_res("gap", 40'd6, 1'b0);

    // Reset mid-frame, then a clean one-beat frame.
    cfg(8'd4, 1'b1, 1'b0);
    beat(PW'(10)); beat(PW'(20));
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_acc_out", 64'(acc_out), 0);
    chk("mrst_busy", 64'(busy), 0);
    chk("mrst_prod_ready", 64'(prod_ready), 0);
    chk("mrst_acc_valid", 64'(acc_valid), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cfg(8'd1, 1'b1, 1'b0);
    beat(PW'(-1));
    wait_res("post_rst", 40'hFF_FFFF_FFFF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
